// File: rtl/seq_shifter_pkg.sv
// Shared constants for the sequential shifter: op codes, FSM state encoding and default width.
package seq_shifter_pkg;

  localparam int DEFAULT_N = 32;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/seq_shifter_step.sv
// One-bit shift/rotate step. Rotate cases exist only when SEQ_SHIFTER_ROTATE_EN is defined;
// otherwise rotate codes fall through to the pass-through default like any reserved op.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0] word,
  input  logic [2:0]   op,
  output logic [N-1:0] stepped
);

  always_comb begin
    stepped = word;
    case (op)
      OP_SLL:  stepped = {word[N-2:0], 1'b0};
      OP_SRL:  stepped = {1'b0, word[N-1:1]};
      OP_SRA:  stepped = {word[N-1], word[N-1:1]};
`ifdef SEQ_SHIFTER_ROTATE_EN
      OP_ROL:  stepped = {word[N-2:0], word[N-1]};
      OP_ROR:  stepped = {word[0], word[N-1:1]};
`endif
      default: stepped = word;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Sequential shifter: one bit per cycle, valid/ready on both sides. Rotates need SEQ_SHIFTER_ROTATE_EN.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1; no bypass from DONE to accept.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [5:0]   sh,
  input  logic [2:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy,
  output logic [1:0]   state_dbg
);

  localparam logic [5:0] N_CNT = 6'(N);

  logic [1:0]   state;
  logic [N-1:0] work;
  logic [2:0]   op_q;
  logic [5:0]   cnt;
  logic [5:0]   eff_cnt;
  logic [N-1:0] stepped;

  // Shifts saturate at N steps; rotates wrap modulo N (N is a power of two).
  always_comb begin
    eff_cnt = '0;
    case (op)
      OP_SLL, OP_SRL, OP_SRA: eff_cnt = (sh > N_CNT) ? N_CNT : sh;
`ifdef SEQ_SHIFTER_ROTATE_EN
      OP_ROL, OP_ROR:         eff_cnt = sh & (N_CNT - 6'd1);
`endif
      default:                eff_cnt = '0;
    endcase
  end

  shift_step #(.N(N)) u_step (
    .word    (work),
    .op      (op_q),
    .stepped (stepped)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      work  <= '0;
      op_q  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            work  <= in_data;
            op_q  <= op;
            cnt   <= eff_cnt;
            state <= (eff_cnt != 6'd0) ? ST_SHIFT : ST_DONE;
          end
        end
        ST_SHIFT: begin
          work <= stepped;
          cnt  <= cnt - 6'd1;
          if (cnt == 6'd1) state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign out_data  = work;
  assign state_dbg = state;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboarded bench for seq_shifter: directed scenarios plus random traffic against a word-level model.
module tb_seq_shifter;
  import seq_shifter_pkg::*;

  localparam int N = 32;

`ifdef SEQ_SHIFTER_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic [5:0]   sh = '0;
  logic [2:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_data;
  logic         busy;
  logic [1:0]   state_dbg;

  seq_shifter #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sh        (sh),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // ---------------- scoreboard state ----------------
  logic [N-1:0] exp_q[$];
  int           lat_q[$];
  int           acc_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  bit           stim_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [N-1:0] ref_result(input logic [N-1:0] d, input logic [2:0] o, input int s);
    logic [2*N-1:0] dd;
    int r;
    r  = s % N;
    dd = {d, d};
    case (o)
      3'b000: return (s >= N) ? '0 : d << s;
      3'b001: return (s >= N) ? '0 : d >> s;
      3'b010: return (s >= N) ? {N{d[N-1]}} : N'($signed(d) >>> s);
      3'b011: begin
        if (!ROT_EN) return d;
        dd = dd << r;
        return dd[2*N-1:N];
      end
      3'b100: begin
        if (!ROT_EN) return d;
        dd = dd >> r;
        return dd[N-1:0];
      end
      default: return d;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input int s);
    if (o <= 3'b010) return ((s >= N) ? N : s) + 1;
    if (ROT_EN && (o == 3'b011 || o == 3'b100)) return (s % N) + 1;
    return 1;
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [N-1:0] d, input logic [2:0] o, input logic [5:0] s);
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    op       = o;
    sh       = s;
    for (int i = 0; i < 300; i++) begin
      if (in_ready) begin
        exp_q.push_back(ref_result(d, o, int'(s)));
        lat_q.push_back(ref_latency(o, int'(s)));
        acc_q.push_back(cycle + 1);
        accepted = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!accepted) check("accept_timeout", 1, 0);
    in_valid = 1'b0;
    in_data  = $urandom;
    op       = 3'($urandom_range(0, 7));
    sh       = 6'($urandom_range(0, 63));
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(negedge clk);
    end
    check("drain", (i < 3000), 1);
  endtask

  // ---------------- monitor ----------------
  logic [N-1:0] cur_exp = '0;
  bit           prev_v  = 1'b0;
  int           lat, exp_lat;

  always @(negedge clk) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          cur_exp = exp_q.pop_front();
          exp_lat = lat_q.pop_front();
          lat     = cycle - acc_q.pop_front() + 1;
          check("data", out_data, cur_exp);
          check("latency", lat, exp_lat);
        end
      end else if (out_valid) begin
        check("stable", out_data, cur_exp);
      end
      if (out_valid) check("in_ready_in_done", in_ready, 0);
      prev_v = out_valid;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_state", state_dbg, ST_IDLE);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    // Directed scenarios
    send(32'hFFFF0000, OP_SLL, 6'd4);
    drain();
    send(32'hFFFF0000, OP_SRA, 6'd3);
    send(32'hFFFF0000, OP_SRL, 6'd3);
    send(32'hFFFF0000, OP_ROR, 6'd36);
    send(32'hFFFF0000, OP_ROL, 6'd7);
    send(32'hA5A5_1234, OP_SLL, 6'd0);
    send(32'hA5A5_1234, 3'b111, 6'd9);
    send(32'hFFFF0000, OP_SRL, 6'd40);
    send(32'h8000_0001, OP_SRA, 6'd50);
    send(32'h7000_0001, OP_SRA, 6'd32);
    send(32'h0000_0001, OP_SLL, 6'd31);
    drain();

    // Stall in DONE with in_valid held and data churning
    out_ready = 1'b0;
    send(32'h1234_5678, OP_SLL, 6'd2);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    check("stall_reached_done", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      op       = 3'($urandom_range(0, 7));
      sh       = 6'($urandom_range(0, 63));
      check("stall_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_data   = 32'hCAFE_F00D;
    op        = OP_SRL;
    sh        = 6'd5;
    check("no_bypass_in_ready", in_ready, 0);
    @(negedge clk);
    check("post_done_idle", state_dbg, ST_IDLE);
    check("post_done_in_ready", in_ready, 1);
    check("post_done_out_valid", out_valid, 0);
    send(32'hCAFE_F00D, OP_SRL, 6'd5);
    drain();

    // Reset mid-SHIFT aborts the request
    send(32'hDEAD_BEEF, OP_SRL, 6'd20);
    repeat (6) @(negedge clk);
    check("mid_shift_busy", busy, 1);
    exp_q.delete();
    lat_q.delete();
    acc_q.delete();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_state", state_dbg, ST_IDLE);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_busy", busy, 0);
    repeat (40) @(negedge clk);

    // Random traffic with random back-pressure
    fork
      begin
        for (int t = 0; t < 150; t++) begin
          logic [N-1:0] d;
          logic [5:0]   s;
          case ($urandom_range(0, 3))
            0: d = 32'h8000_0000 | 32'($urandom);
            1: d = 32'h0000_0001 << $urandom_range(0, 31);
            default: d = $urandom;
          endcase
          s = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 12));
          send(d, 3'($urandom_range(0, 7)), s);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
